// File: rtl/trace_arbiter.sv
// trace_arbiter: two-source trace ingress arbiter. It places a small FIFO on
// each source and issues at most one word per cycle to the mapping datapath.
// Sources alternate on contention, the downstream stall is honoured, and each
// source has a saturating grant counter.
module trace_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      s0_trace,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  logic [31:0]      s1_trace,
    input  logic             s1_valid,
    output logic             s1_ready,
    input  logic             stall,
    output logic [31:0]      trace,
    output logic             trace_valid,
    output logic             trace_src,
    output logic [CNT_W-1:0] s0_grants,
    output logic [CNT_W-1:0] s1_grants
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    logic [31:0]      mem0_q [DEPTH];
    logic [31:0]      mem1_q [DEPTH];
    logic [PW-1:0]    wptr0_q, wptr0_d, rptr0_q, rptr0_d;
    logic [PW-1:0]    wptr1_q, wptr1_d, rptr1_q, rptr1_d;
    logic [OW-1:0]    occ0_q, occ0_d, occ1_q, occ1_d;
    logic             last_grant_q, last_grant_d;
    logic [31:0]      trace_q, trace_d;
    logic             trace_valid_q, trace_valid_d;
    logic             trace_src_q, trace_src_d;
    logic [CNT_W-1:0] grants0_q, grants0_d, grants1_q, grants1_d;

    logic push0, push1, pop0, pop1;
    logic ne0, ne1;

    // Handshake and pop decision, taken from registered occupancy only so no
    // input reaches an output combinationally.
    always_comb begin
        push0 = s0_valid && (occ0_q != FULL);
        push1 = s1_valid && (occ1_q != FULL);
        ne0   = (occ0_q != '0);
        ne1   = (occ1_q != '0);
        pop0  = 1'b0;
        pop1  = 1'b0;
        if (!stall) begin
            if (ne0 && ne1) begin
                if (last_grant_q) pop0 = 1'b1;
                else              pop1 = 1'b1;
            end else if (ne0) begin
                pop0 = 1'b1;
            end else if (ne1) begin
                pop1 = 1'b1;
            end
        end
    end

    // Next-state for pointers, occupancies, grant state and the output register.
    always_comb begin
        wptr0_d       = wptr0_q;
        rptr0_d       = rptr0_q;
        wptr1_d       = wptr1_q;
        rptr1_d       = rptr1_q;
        occ0_d        = occ0_q + OW'(push0) - OW'(pop0);
        occ1_d        = occ1_q + OW'(push1) - OW'(pop1);
        last_grant_d  = last_grant_q;
        trace_d       = trace_q;
        trace_src_d   = trace_src_q;
        trace_valid_d = pop0 || pop1;
        grants0_d     = grants0_q;
        grants1_d     = grants1_q;

        if (push0) wptr0_d = wptr0_q + PW'(1);
        if (push1) wptr1_d = wptr1_q + PW'(1);

        if (pop0) begin
            rptr0_d      = rptr0_q + PW'(1);
            last_grant_d = 1'b0;
            trace_d      = mem0_q[rptr0_q];
            trace_src_d  = 1'b0;
            if (grants0_q != '1) grants0_d = grants0_q + CNT_W'(1);
        end else if (pop1) begin
            rptr1_d      = rptr1_q + PW'(1);
            last_grant_d = 1'b1;
            trace_d      = mem1_q[rptr1_q];
            trace_src_d  = 1'b1;
            if (grants1_q != '1) grants1_d = grants1_q + CNT_W'(1);
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push0) mem0_q[wptr0_q] <= s0_trace;
        if (push1) mem1_q[wptr1_q] <= s1_trace;
    end

    // State registers, cleared asynchronously; last_grant starts at 1 so source 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr0_q       <= '0;
            rptr0_q       <= '0;
            wptr1_q       <= '0;
            rptr1_q       <= '0;
            occ0_q        <= '0;
            occ1_q        <= '0;
            last_grant_q  <= 1'b1;
            trace_q       <= '0;
            trace_valid_q <= 1'b0;
            trace_src_q   <= 1'b0;
            grants0_q     <= '0;
            grants1_q     <= '0;
        end else begin
            wptr0_q       <= wptr0_d;
            rptr0_q       <= rptr0_d;
            wptr1_q       <= wptr1_d;
            rptr1_q       <= rptr1_d;
            occ0_q        <= occ0_d;
            occ1_q        <= occ1_d;
            last_grant_q  <= last_grant_d;
            trace_q       <= trace_d;
            trace_valid_q <= trace_valid_d;
            trace_src_q   <= trace_src_d;
            grants0_q     <= grants0_d;
            grants1_q     <= grants1_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        s0_ready    = (occ0_q != FULL);
        s1_ready    = (occ1_q != FULL);
        trace       = trace_q;
        trace_valid = trace_valid_q;
        trace_src   = trace_src_q;
        s0_grants   = grants0_q;
        s1_grants   = grants1_q;
    end

endmodule

// File: tb/tb_trace_arbiter.sv
// Testbench for trace_arbiter: directed stimulus with a scoreboard of expected
// issued words (word, source) checked whenever trace_valid is seen.
module tb_trace_arbiter;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          clk_run;
    logic          reset;
    logic [31:0]   s0_trace, s1_trace;
    logic          s0_valid, s1_valid;
    logic          s0_ready, s1_ready;
    logic          stall;
    logic [31:0]   trace;
    logic          trace_valid;
    logic          trace_src;
    logic [CW-1:0] s0_grants, s1_grants;

    typedef struct {
        logic [31:0] word;
        logic        src;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    trace_arbiter #(.DEPTH(4), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .s0_trace   (s0_trace),
        .s0_valid   (s0_valid),
        .s0_ready   (s0_ready),
        .s1_trace   (s1_trace),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .stall      (stall),
        .trace      (trace),
        .trace_valid(trace_valid),
        .trace_src  (trace_src),
        .s0_grants  (s0_grants),
        .s1_grants  (s1_grants)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] w, input logic s);
        exp_t e;
        e.word = w;
        e.src  = s;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            cyc();
            n++;
        end
        repeat (2) cyc();
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every issued word must be the next expected one.
    always @(negedge clk) begin
        if (trace_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_issue", 64'(trace_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("issue_word", 64'(trace), 64'(e.word));
                chk("issue_src", 64'(trace_src), 64'(e.src));
            end
        end
    end

    initial begin
        clk_run  = 1'b0;
        reset    = 1'b1;
        s0_trace = '0;
        s1_trace = '0;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        stall    = 1'b0;

        // Reset with no clock running.
        #2;
        chk("rst_trace", 64'(trace), 64'd0);
        chk("rst_valid", 64'(trace_valid), 64'd0);
        chk("rst_src", 64'(trace_src), 64'd0);
        chk("rst_g0", 64'(s0_grants), 64'd0);
        chk("rst_g1", 64'(s1_grants), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_rdy0", 64'(s0_ready), 64'd1);
        chk("rst_rdy1", 64'(s1_ready), 64'd1);
        clk_run = 1'b1;
        cyc();

        // Contention: preload both FIFOs under stall, then release.
        stall = 1'b1;
        s0_valid = 1'b1; s1_valid = 1'b1;
        s0_trace = 32'h10; s1_trace = 32'h20;
        cyc();
        s0_trace = 32'h11; s1_trace = 32'h21;
        cyc();
        s0_valid = 1'b0; s1_valid = 1'b0;
        expect_word(32'h10, 1'b0);
        expect_word(32'h20, 1'b1);
        expect_word(32'h11, 1'b0);
        expect_word(32'h21, 1'b1);
        cyc();
        stall = 1'b0;
        drain(20);
        chk("cont_g0", 64'(s0_grants), 64'd2);
        chk("cont_g1", 64'(s1_grants), 64'd2);

        // Single source, consecutive pushes.
        s0_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            s0_trace = 32'hA000_0000 + 32'(i);
            expect_word(s0_trace, 1'b0);
            cyc();
            chk("single_first_issue", 64'(trace_valid), 64'(i > 1 ? 1 : 0));
        end
        s0_valid = 1'b0;
        cyc();
        chk("single_third_issue", 64'(trace_valid), 64'd1);
        drain(20);
        chk("single_g0", 64'(s0_grants), 64'd5);

        // Full FIFO under stall, then reopen after the first pop.
        stall = 1'b1;
        s1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s1_trace = 32'hB000_0000 + 32'(i);
            expect_word(s1_trace, 1'b1);
            chk("full_rdy_open", 64'(s1_ready), 64'd1);
            cyc();
        end
        chk("full_rdy_closed", 64'(s1_ready), 64'd0);
        s1_trace = 32'hB000_0004;
        expect_word(s1_trace, 1'b1);
        cyc();
        chk("full_rdy_stalled", 64'(s1_ready), 64'd0);
        stall = 1'b0;
        cyc();
        chk("full_rdy_reopen", 64'(s1_ready), 64'd1);
        cyc();
        s1_valid = 1'b0;
        drain(20);
        chk("full_g1", 64'(s1_grants), 64'd7);

        // Reset mid-operation with three words queued on s0.
        stall = 1'b1;
        s0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s0_trace = 32'hC000_0000 + 32'(i);
            cyc();
        end
        s0_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valid", 64'(trace_valid), 64'd0);
        chk("midrst_g0", 64'(s0_grants), 64'd0);
        chk("midrst_rdy0", 64'(s0_ready), 64'd1);
        chk("midrst_trace", 64'(trace), 64'd0);
        cyc();
        reset = 1'b0;
        stall = 1'b0;
        repeat (4) cyc();
        s0_valid = 1'b1;
        s0_trace = 32'h0000_BEEF;
        expect_word(s0_trace, 1'b0);
        cyc();
        s0_valid = 1'b0;
        drain(20);
        chk("midrst_g0_after", 64'(s0_grants), 64'd1);

        // Grant counter saturation with a 4-bit counter.
        s0_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s0_trace = 32'hD000_0000 + 32'(i);
            expect_word(s0_trace, 1'b0);
            cyc();
        end
        s0_valid = 1'b0;
        drain(40);
        chk("sat_g0", 64'(s0_grants), 64'd15);
        chk("sat_g1", 64'(s1_grants), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1);
    end

endmodule
